sdram_rr_arb: RTL
=================

SDRAM_RR_ARB -- requirements
Module: sdram_rr_arb

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4: depth of the ack-routing order FIFO, a power of 2 in the range 2..16.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset, named as below.
REQ-003 ACLK  in  1  single clock; all state changes on its rising edge.
REQ-004 ARSTN  in  1  asynchronous active-low reset.
REQ-005 portA_wr_i  in  4  byte write strobes; any bit set = write request.
REQ-006 portA_rd_i  in  1  read request.
REQ-007 portA_addr_i  in  32  byte address.
REQ-008 portA_write_data_i  in  32  write data.
REQ-009 portA_accept_o  out  1  request taken this cycle.
REQ-010 portA_ack_o  out  1  response for the oldest accepted portA request.
REQ-011 portA_error_o  out  1  error qualifier, valid with portA_ack_o.
REQ-012 portA_read_data_o  out  32  read data, valid with portA_ack_o.
REQ-013 portB_* SHALL be an identical set of 8 ports with identical meaning.
REQ-014 core_wr_o / core_rd_o  out  4 / 1  request to sdram32 inport.
REQ-015 core_addr_o / core_write_data_o  out  32 / 32  forwarded address and data.
REQ-016 core_accept_i / core_ack_i / core_error_i  in  1 / 1 / 1  sdram32 handshake.
REQ-017 core_read_data_i  in  32  sdram32 read data.

Function
REQ-018 reqX = |portX_wr_i | portX_rd_i; a requester SHALL hold wr/rd/addr/data stable until portX_accept_o.
REQ-019 Grant states: IDLE, GNT_A, GNT_B. From IDLE: one requester -> grant it; both -> grant the port other than last_winner. Evaluation is combinational, so a request can be accepted in the cycle it first appears.
REQ-020 While GNT_X and not accepted, the grant SHALL stay locked to X; the other port cannot take over.
REQ-021 core_* outputs SHALL mux the granted port's signals; with no grant or fifo_full, core_wr_o=0 and core_rd_o=0.
REQ-022 portX_accept_o = core_accept_i & grant==X & !fifo_full & reqX; the other port's accept SHALL be 0.
REQ-023 On accept: push X into the order FIFO, set last_winner=X, go to IDLE. Back-to-back accepts SHALL be possible every cycle, alternating when both ports request.
REQ-024 On core_ack_i with FIFO non-empty: pop the head H; portH_ack_o=1 and portH_error_o=core_error_i, both combinational, same cycle; other port ack/error SHALL be 0.
REQ-025 portA_read_data_o and portB_read_data_o SHALL both equal core_read_data_i; qualified only by their own ack.
REQ-026 Push and pop in the same cycle SHALL leave the occupancy unchanged; ordering SHALL be preserved.
REQ-027 core_ack_i with FIFO empty SHALL be dropped: no port ack, state unchanged.
REQ-028 fifo_full (occupancy==MAX_OUTSTANDING) SHALL block new accepts; a pop in the same cycle does not unblock until the next cycle.
REQ-029 Occupancy counter width SHALL be clog2(MAX_OUTSTANDING)+1 bits; pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-030 On ARSTN low, asynchronously: state=IDLE, last_winner=B (A wins the first tie), FIFO empty, pointers=0.
REQ-031 During reset, all accept/ack/error outputs and core_wr_o/core_rd_o SHALL be 0.
REQ-032 Reset mid-transaction SHALL discard outstanding entries; acks arriving after reset SHALL be dropped per REQ-027.

Verification
REQ-033 Release reset; A and B both read every cycle, core_accept_i=1 -> core grants A,B,A,B...; each port gets exactly one accept per 2 cycles.
REQ-034 B write wstrb=4'hF, addr 0x100, core_accept_i=0 for 3 cycles, then A requests -> grant stays B; B accepted when core_accept_i=1; A accepted next cycle.
REQ-035 Issue reads A,B,A; acks with read_data 0x11,0x22,0x33 and core_error_i=1 on the 2nd -> A gets 0x11; then B gets ack with error=1 and 0x22; then A gets 0x33.
REQ-036 MAX_OUTSTANDING=4, no acks -> after 4 accepts, accept=0 and core_rd_o=0; single ack -> accept resumes the following cycle.
REQ-037 Spurious core_ack_i with FIFO empty -> no port ack; an ack arriving while 2 requests are outstanding and ARSTN is pulsed -> dropped; next request accepted normally, A winning the first tie.

Source files
------------

// File: rtl/sdram_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rr_arb
// Description : Two-port round-robin arbiter that sits in front of an sdram32
//               inport. Requests from port A and port B are forwarded to the
//               core one at a time. The port that owns each accepted request
//               is recorded in a small order FIFO, so that every core ack goes
//               back to the port that issued the oldest outstanding request.
// Ports       : ACLK, ARSTN            - clock, asynchronous active-low reset
//               portX_wr_i/rd_i        - X = A or B; request strobes
//               portX_addr_i/write_data_i - request payload
//               portX_accept_o         - request taken this cycle
//               portX_ack_o/error_o/read_data_o - response routed to port X
//               core_*                 - sdram32 inport request and response
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rr_arb #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        ACLK,
    input  logic        ARSTN,
    input  logic [3:0]  portA_wr_i,
    input  logic        portA_rd_i,
    input  logic [31:0] portA_addr_i,
    input  logic [31:0] portA_write_data_i,
    output logic        portA_accept_o,
    output logic        portA_ack_o,
    output logic        portA_error_o,
    output logic [31:0] portA_read_data_o,
    input  logic [3:0]  portB_wr_i,
    input  logic        portB_rd_i,
    input  logic [31:0] portB_addr_i,
    input  logic [31:0] portB_write_data_i,
    output logic        portB_accept_o,
    output logic        portB_ack_o,
    output logic        portB_error_o,
    output logic [31:0] portB_read_data_o,
    output logic [3:0]  core_wr_o,
    output logic        core_rd_o,
    output logic [31:0] core_addr_o,
    output logic [31:0] core_write_data_o,
    input  logic        core_accept_i,
    input  logic        core_ack_i,
    input  logic        core_error_i,
    input  logic [31:0] core_read_data_i
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

    // Port identifiers as stored in the order FIFO and in last_winner.
    localparam logic c_port_a = 1'b0;
    localparam logic c_port_b = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t                  state_q,       state_d;
    logic                    last_winner_q, last_winner_d;
    logic [MAX_OUTSTANDING-1:0] order_q,    order_d;
    logic [PTR_W-1:0]        wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0]        count_q,       count_d;

    logic w_req_a, w_req_b;
    logic w_gnt_a, w_gnt_b;
    logic w_full, w_issue;
    logic w_push, w_pop, w_head;

    assign w_req_a = (|portA_wr_i) | portA_rd_i;
    assign w_req_b = (|portB_wr_i) | portB_rd_i;

    // Grant selection. A locked grant only holds while its requester is still
    // asking, so a misbehaving port that drops its request cannot stall the
    // arbiter forever.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        case (state_q)
            GNT_A: w_gnt_a = w_req_a;
            GNT_B: w_gnt_b = w_req_b;
            default: begin
                if (w_req_a && w_req_b) begin
                    w_gnt_a = (last_winner_q == c_port_b);
                    w_gnt_b = (last_winner_q == c_port_a);
                end else begin
                    w_gnt_a = w_req_a;
                    w_gnt_b = w_req_b;
                end
            end
        endcase
    end

    // Reset is folded in so that nothing is issued or accepted while ARSTN
    // is low, even though the grant logic itself is purely combinational.
    assign w_full  = (count_q == c_cnt_full);
    assign w_issue = ARSTN & ~w_full;

    always_comb begin
        core_wr_o         = 4'h0;
        core_rd_o         = 1'b0;
        core_addr_o       = portA_addr_i;
        core_write_data_o = portA_write_data_i;
        if (w_gnt_b) begin
            core_addr_o       = portB_addr_i;
            core_write_data_o = portB_write_data_i;
        end
        if (w_issue && w_gnt_a) begin
            core_wr_o = portA_wr_i;
            core_rd_o = portA_rd_i;
        end else if (w_issue && w_gnt_b) begin
            core_wr_o = portB_wr_i;
            core_rd_o = portB_rd_i;
        end
    end

    assign portA_accept_o = core_accept_i & w_issue & w_gnt_a & w_req_a;
    assign portB_accept_o = core_accept_i & w_issue & w_gnt_b & w_req_b;
    assign w_push         = portA_accept_o | portB_accept_o;

    // Acks with nothing outstanding are dropped here.
    assign w_pop  = ARSTN & core_ack_i & (count_q != '0);
    assign w_head = order_q[rd_ptr_q];

    assign portA_ack_o       = w_pop & (w_head == c_port_a);
    assign portB_ack_o       = w_pop & (w_head == c_port_b);
    assign portA_error_o     = portA_ack_o & core_error_i;
    assign portB_error_o     = portB_ack_o & core_error_i;
    assign portA_read_data_o = core_read_data_i;
    assign portB_read_data_o = core_read_data_i;

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        order_d       = order_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (w_push) begin
            state_d       = IDLE;
            last_winner_d = portB_accept_o ? c_port_b : c_port_a;
            order_d[wr_ptr_q] = portB_accept_o ? c_port_b : c_port_a;
            wr_ptr_d      = wr_ptr_q + c_ptr_one;
        end else if (w_gnt_a) begin
            state_d = GNT_A;
        end else if (w_gnt_b) begin
            state_d = GNT_B;
        end else begin
            state_d = IDLE;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state_q       <= IDLE;
            last_winner_q <= c_port_b;
            order_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            order_q       <= order_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule
`default_nettype wire
